// File: rtl/axi_ram_pkg.sv
// Shared types and helpers for the AXI RAM slave and its burst address generator.
package axi_ram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational burst address step plus range and burst-legality checks.
module axi_burst_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTES      = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  burst_t                burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  cur_ok,
    output logic                  next_ok,
    output logic                  burst_err
);

    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Illegal bursts fall back to INCR stepping; the error is reported separately
    always_comb begin
        burst_err = (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
        incr_addr = addr + ADDR_WIDTH'(BYTES);
        wrap_mask = ADDR_WIDTH'(BYTES) * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = burst_err ? incr_addr
                                               : ((addr & ~wrap_mask) | (incr_addr & wrap_mask));
            default:     next_addr = incr_addr;
        endcase
        cur_ok  = {1'b0, addr} < LIMIT;
        next_ok = {1'b0, next_addr} < LIMIT;
    end

endmodule

// File: rtl/axi_ram_slave_burst.sv
// AXI4 RAM slave: one outstanding write and one outstanding read, independent FSMs.
module axi_ram_slave_burst
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int DL    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        burst_t                burst;
    } ax_req_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    wr_state_t             w_state;
    ax_req_t               w_req;
    logic [7:0]            w_cnt;
    logic                  w_err, w_oor;
    logic [ADDR_WIDTH-1:0] w_gen_addr, w_next;
    logic [7:0]            w_gen_len;
    burst_t                w_gen_burst;
    logic                  w_cur_ok, w_next_ok, w_burst_err;
    logic                  w_fire, w_mem_en, w_beat_err;

    // While idle the generator looks at the incoming AW so its checks can be latched
    always_comb begin
        w_gen_addr  = (w_state == W_IDLE) ? (awaddr & ALIGN_MASK) : w_req.addr;
        w_gen_len   = (w_state == W_IDLE) ? awlen : w_req.len;
        w_gen_burst = (w_state == W_IDLE) ? burst_t'(awburst) : w_req.burst;
        w_fire      = (w_state == W_DATA) && wvalid && wready;
        w_mem_en    = aresetn && w_fire && w_cur_ok && !w_oor;
        w_beat_err  = !w_cur_ok || w_oor || (wlast != (w_cnt == 8'd0));
    end

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES), .MEM_DEPTH(MEM_DEPTH)
    ) u_wgen (
        .addr(w_gen_addr), .len(w_gen_len), .burst(w_gen_burst),
        .next_addr(w_next), .cur_ok(w_cur_ok), .next_ok(w_next_ok), .burst_err(w_burst_err)
    );

    // Byte-strobed memory write; contents survive reset
    always_ff @(posedge aclk) begin
        if (w_mem_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[w_req.addr[BL +: DL]][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Write FSM: accept AW, count W beats, then hold B until accepted
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            w_req   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_oor   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        w_req   <= '{id: awid, addr: awaddr & ALIGN_MASK, len: awlen,
                                     burst: burst_t'(awburst)};
                        w_cnt   <= awlen;
                        w_err   <= w_burst_err;
                        w_oor   <= !w_cur_ok;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_beat_err) w_err <= 1'b1;
                        w_req.addr <= w_next;
                        w_cnt      <= w_cnt - 8'd1;
                        // the beat counter, not wlast, ends the burst
                        if (w_cnt == 8'd0) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_req.id;
                            bresp   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rd_state_t             r_state;
    ax_req_t               r_req;
    logic [7:0]            r_cnt;
    logic                  r_err, r_oor;
    logic [ADDR_WIDTH-1:0] r_gen_addr, r_next;
    logic [7:0]            r_gen_len;
    burst_t                r_gen_burst;
    logic                  r_cur_ok, r_next_ok, r_burst_err;

    always_comb begin
        r_gen_addr  = (r_state == R_IDLE) ? (araddr & ALIGN_MASK) : r_req.addr;
        r_gen_len   = (r_state == R_IDLE) ? arlen : r_req.len;
        r_gen_burst = (r_state == R_IDLE) ? burst_t'(arburst) : r_req.burst;
    end

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES), .MEM_DEPTH(MEM_DEPTH)
    ) u_rgen (
        .addr(r_gen_addr), .len(r_gen_len), .burst(r_gen_burst),
        .next_addr(r_next), .cur_ok(r_cur_ok), .next_ok(r_next_ok), .burst_err(r_burst_err)
    );

    // Read FSM: r_req.addr tracks the beat on the bus; the next beat is fetched on handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rid     <= '0;
            rdata   <= '0;
            r_req   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        r_req   <= '{id: arid, addr: araddr & ALIGN_MASK, len: arlen,
                                     burst: burst_t'(arburst)};
                        r_cnt   <= arlen;
                        r_err   <= r_burst_err;
                        r_oor   <= !r_cur_ok;
                        rid     <= arid;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 8'd0);
                        rresp   <= (r_burst_err || !r_cur_ok) ? RESP_SLVERR : RESP_OKAY;
                        rdata   <= r_cur_ok ? mem[r_gen_addr[BL +: DL]] : '0;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (r_cnt == 8'd0) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_req.addr <= r_next;
                            r_cnt      <= r_cnt - 8'd1;
                            rlast      <= (r_cnt == 8'd1);
                            rresp      <= (r_err || r_oor || !r_next_ok) ? RESP_SLVERR : RESP_OKAY;
                            rdata      <= (r_next_ok && !r_oor) ? mem[r_next[BL +: DL]] : '0;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave_burst.sv
// Directed bench for axi_ram_slave_burst (32-bit data, 1024 words).
module tb_axi_ram_slave_burst;

    logic        aclk, aresetn;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_ram_slave_burst dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int passed = 0;

    // write helper state
    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    bit          wr_nolast;
    int          wr_bdelay;
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;
    logic        wr_b_t1;
    int          wr_stall_ok;
    bit          wr_tmo;

    // read helper state
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    logic        rd_t1, rd_after;
    bit          rd_tmo;

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, output bit ok);
        logic hs = 1'b0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin hs = awready; tick(); end
        awvalid = 1'b0;
        ok = hs;
    endtask

    task automatic w_hs(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
        logic hs = 1'b0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin hs = wready; tick(); end
        wvalid = 1'b0; wlast = 1'b0;
        ok = hs;
    endtask

    task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, output bit ok);
        logic hs = 1'b0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin hs = arready; tick(); end
        arvalid = 1'b0;
        ok = hs;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        bit ok;
        int n;
        wr_tmo = 0; wr_stall_ok = 0;
        aw_hs(id, addr, len, burst, ok);
        if (!ok) wr_tmo = 1;
        for (int b = 0; b <= int'(len); b++) begin
            w_hs(wr_data[b], wr_strb[b], wr_nolast ? 1'b0 : (b == int'(len)), ok);
            if (!ok) wr_tmo = 1;
        end
        wr_b_t1 = bvalid;
        for (int i = 0; i < wr_bdelay; i++) begin
            if (bvalid && !awready) wr_stall_ok++;
            tick();
        end
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (!bvalid) wr_tmo = 1;
        wr_bresp = bresp; wr_bid = bid;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok;
        int n;
        rd_tmo = 0;
        ar_hs(id, addr, len, burst, ok);
        if (!ok) rd_tmo = 1;
        rd_t1 = rvalid;
        rready = 1'b1;
        for (int b = 0; b <= int'(len) && b < 16; b++) begin
            n = 0;
            while (!rvalid && n < 20) begin tick(); n++; end
            if (!rvalid) rd_tmo = 1;
            rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; rd_id = rid;
            tick();
        end
        rready = 1'b0;
        rd_after = rvalid;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        total++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
            $display("FAIL reset_ctrl got %b exp 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        else passed++;
        total++;
        if ({bresp, bid, rresp, rid} !== 12'h0)
            $display("FAIL reset_resp_id got %h exp 000", {bresp, bid, rresp, rid});
        else passed++;
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rdata);
        else passed++;
        aresetn = 1'b1;
        tick();
        total++;
        if ({awready, arready} !== 2'b11)
            $display("FAIL idle_ready got %b exp 11", {awready, arready});
        else passed++;
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + i; wr_strb[i] = 4'hF; end
        do_write(4'd5, 32'h10, 8'd3, 2'b01);
        total++;
        if (wr_tmo || wr_bresp !== 2'b00) $display("FAIL incr_bresp got %b tmo %0d exp 00", wr_bresp, wr_tmo);
        else passed++;
        total++;
        if (wr_bid !== 4'd5) $display("FAIL incr_bid got %0d exp 5", wr_bid);
        else passed++;
        total++;
        if (wr_b_t1 !== 1'b1) $display("FAIL incr_b_latency got bvalid %b exp 1", wr_b_t1);
        else passed++;
        do_read(4'd6, 32'h10, 8'd3, 2'b01);
        total++;
        if (rd_tmo || rd_t1 !== 1'b1) $display("FAIL incr_r_latency got rvalid %b tmo %0d exp 1", rd_t1, rd_tmo);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== 32'hA0 + i || rd_resp[i] !== 2'b00)
                $display("FAIL incr_rdata[%0d] got %h/%b exp %h/00", i, rd_data[i], rd_resp[i], 32'hA0 + i);
            else passed++;
            total++;
            if (rd_last[i] !== (i == 3)) $display("FAIL incr_rlast[%0d] got %b exp %b", i, rd_last[i], i == 3);
            else passed++;
        end
        total++;
        if (rd_id !== 4'd6 || rd_after !== 1'b0)
            $display("FAIL incr_rid_end got id %0d rvalid %b exp 6/0", rd_id, rd_after);
        else passed++;
    endtask

    task automatic test_strobe();
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        do_write(4'd1, 32'h20, 8'd0, 2'b01);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
        do_write(4'd1, 32'h20, 8'd0, 2'b01);
        do_read(4'd1, 32'h20, 8'd0, 2'b01);
        total++;
        if (rd_tmo || rd_data[0] !== 32'h11BB33DD) $display("FAIL strobe got %h exp 11bb33dd", rd_data[0]);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hC2; exp_d[1] = 32'hC3; exp_d[2] = 32'hC0; exp_d[3] = 32'hC1;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hC0 + i; wr_strb[i] = 4'hF; end
        do_write(4'd2, 32'h30, 8'd3, 2'b01);
        do_read(4'd2, 32'h38, 8'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_tmo || rd_data[i] !== exp_d[i] || rd_resp[i] !== 2'b00)
                $display("FAIL wrap_beat[%0d] got %h/%b exp %h/00", i, rd_data[i], rd_resp[i], exp_d[i]);
            else passed++;
        end
        do_read(4'd2, 32'h38, 8'd2, 2'b10);
        total++;
        if (rd_tmo || {rd_resp[0], rd_resp[1], rd_resp[2]} !== 6'b101010)
            $display("FAIL wrap_badlen_resp got %b%b%b exp 101010", rd_resp[0], rd_resp[1], rd_resp[2]);
        else passed++;
        total++;
        if (rd_data[0] !== 32'hC2 || rd_data[1] !== 32'hC3 || rd_last[2] !== 1'b1)
            $display("FAIL wrap_badlen_incr got %h %h last %b exp c2 c3 1", rd_data[0], rd_data[1], rd_last[2]);
        else passed++;
    endtask

    task automatic test_oor();
        wr_data[0] = 32'h5A5A5A5A; wr_strb[0] = 4'hF;
        do_write(4'd3, 32'h0, 8'd0, 2'b01);
        wr_data[0] = 32'hFFFFFFFF;
        do_write(4'd3, 32'h1000, 8'd0, 2'b01);
        total++;
        if (wr_tmo || wr_bresp !== 2'b10) $display("FAIL oor_bresp got %b exp 10", wr_bresp);
        else passed++;
        do_read(4'd3, 32'h0, 8'd0, 2'b01);
        total++;
        if (rd_data[0] !== 32'h5A5A5A5A) $display("FAIL oor_mem_untouched got %h exp 5a5a5a5a", rd_data[0]);
        else passed++;
        wr_data[0] = 32'hDEADBEEF;
        do_write(4'd3, 32'hFFC, 8'd0, 2'b01);
        do_read(4'd3, 32'hFFC, 8'd1, 2'b01);
        total++;
        if (rd_tmo || rd_data[0] !== 32'hDEADBEEF || rd_resp[0] !== 2'b00)
            $display("FAIL oor_top_beat0 got %h/%b exp deadbeef/00", rd_data[0], rd_resp[0]);
        else passed++;
        total++;
        if (rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b10)
            $display("FAIL oor_top_beat1 got %h/%b exp 0/10", rd_data[1], rd_resp[1]);
        else passed++;
        do_read(4'd3, 32'h1000, 8'd0, 2'b01);
        total++;
        if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'b10)
            $display("FAIL oor_read got %h/%b exp 0/10", rd_data[0], rd_resp[0]);
        else passed++;
    endtask

    task automatic test_errors();
        for (int i = 0; i < 2; i++) begin wr_data[i] = 32'h70 + i; wr_strb[i] = 4'hF; end
        do_write(4'd4, 32'h70, 8'd1, 2'b11);
        total++;
        if (wr_tmo || wr_bresp !== 2'b10) $display("FAIL rsvd_burst_bresp got %b exp 10", wr_bresp);
        else passed++;
        wr_nolast = 1;
        do_write(4'd4, 32'h78, 8'd1, 2'b01);
        wr_nolast = 0;
        total++;
        if (wr_tmo || wr_bresp !== 2'b10) $display("FAIL wlast_mismatch_bresp got %b exp 10", wr_bresp);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit   ok;
        logic pat [10];
        logic [31:0] got [4];
        logic [31:0] prev_d;
        logic prev_l, stalled;
        int   k = 0, stall_bad = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ar_hs(4'd7, 32'h10, 8'd3, 2'b01, ok);
        for (int c = 0; c < 10 && k < 4; c++) begin
            rready = pat[c];
            stalled = rvalid && !rready;
            prev_d = rdata; prev_l = rlast;
            if (rvalid && rready) begin
                got[k] = rdata;
                if (rlast !== (k == 3)) stall_bad++;
                k++;
            end
            tick();
            if (stalled && (rdata !== prev_d || rlast !== prev_l || rvalid !== 1'b1)) stall_bad++;
        end
        rready = 1'b0;
        total++;
        if (!ok || k != 4) $display("FAIL bp_beats got %0d exp 4", k);
        else passed++;
        total++;
        if (stall_bad != 0) $display("FAIL bp_stable got %0d bad cycles exp 0", stall_bad);
        else passed++;
        for (int i = 0; i < k; i++) begin
            total++;
            if (got[i] !== 32'hA0 + i) $display("FAIL bp_data[%0d] got %h exp %h", i, got[i], 32'hA0 + i);
            else passed++;
        end
        wr_data[0] = 32'h44; wr_strb[0] = 4'hF; wr_bdelay = 5;
        do_write(4'd8, 32'h44, 8'd0, 2'b01);
        wr_bdelay = 0;
        total++;
        if (wr_stall_ok != 5) $display("FAIL b_hold got %0d cycles exp 5", wr_stall_ok);
        else passed++;
        total++;
        if (wr_tmo || wr_bresp !== 2'b00 || wr_bid !== 4'd8)
            $display("FAIL b_hold_resp got %b/%0d exp 00/8", wr_bresp, wr_bid);
        else passed++;
    endtask

    task automatic test_concurrent();
        bit ok;
        int n = 0;
        wr_data[0] = 32'h1111; wr_strb[0] = 4'hF;
        do_write(4'd9, 32'h60, 8'd0, 2'b01);
        aw_hs(4'd9, 32'h60, 8'd0, 2'b01, ok);
        wdata = 32'h2222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        arid = 4'd9; araddr = 32'h60; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        total++;
        if (!ok || wready !== 1'b1 || arready !== 1'b1)
            $display("FAIL conc_ready got w %b ar %b exp 1 1", wready, arready);
        else passed++;
        tick();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h1111)
            $display("FAIL conc_prewrite got %b/%h exp 1/00001111", rvalid, rdata);
        else passed++;
        rready = 1'b1; tick(); rready = 1'b0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin tick(); n++; end
        tick(); bready = 1'b0;
        do_read(4'd9, 32'h60, 8'd0, 2'b01);
        total++;
        if (rd_tmo || rd_data[0] !== 32'h2222) $display("FAIL conc_postwrite got %h exp 00002222", rd_data[0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2, ok3;
        aw_hs(4'd10, 32'h50, 8'd3, 2'b01, ok1);
        w_hs(32'h50, 4'hF, 1'b0, ok2);
        w_hs(32'h51, 4'hF, 1'b0, ok3);
        aresetn = 1'b0;
        tick();
        total++;
        if (!(ok1 && ok2 && ok3) || {awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
            $display("FAIL midrst_ctrl got %b exp 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        else passed++;
        total++;
        if ({bresp, bid, rresp, rid} !== 12'h0 || rdata !== 32'h0)
            $display("FAIL midrst_data got %h/%h exp 000/0", {bresp, bid, rresp, rid}, rdata);
        else passed++;
        aresetn = 1'b1;
        tick();
        wr_data[0] = 32'h77; wr_strb[0] = 4'hF;
        do_write(4'd11, 32'h50, 8'd0, 2'b01);
        total++;
        if (wr_tmo || wr_bresp !== 2'b00 || wr_bid !== 4'd11)
            $display("FAIL midrst_newwr got %b/%0d exp 00/11", wr_bresp, wr_bid);
        else passed++;
        do_read(4'd11, 32'h50, 8'd0, 2'b01);
        total++;
        if (rd_tmo || rd_data[0] !== 32'h77 || rd_resp[0] !== 2'b00)
            $display("FAIL midrst_newrd got %h/%b exp 77/00", rd_data[0], rd_resp[0]);
        else passed++;
    endtask

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
        wr_nolast = 0; wr_bdelay = 0;
        test_reset();
        test_incr();
        test_strobe();
        test_wrap();
        test_oor();
        test_errors();
        test_backpressure();
        test_concurrent();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
